uart_alu_intf: RTL

UART_ALU_INTF -- requirements
Module: uart_alu_intf

---
 rtl/uart_alu_intf.sv | 102 ++++++++++
 1 files changed

// File: rtl/uart_alu_intf.sv
// Byte-serial ALU front end: collects A, B and an opcode from a UART receiver
// and hands the result byte to a UART transmitter.
module uart_alu_intf #(
    parameter int DBIT  = 8,
    parameter int OPBIT = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_data,
    input  logic            tx_done_tick,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    output logic            busy,
    output logic            op_err,
    output logic            ovr_tick
);

    typedef enum logic [2:0] {
        IDLE_A,
        WAIT_B,
        WAIT_OP,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [OPBIT-1:0] OP_ADD = OPBIT'(6'b100000);
    localparam logic [OPBIT-1:0] OP_SUB = OPBIT'(6'b100010);
    localparam logic [OPBIT-1:0] OP_AND = OPBIT'(6'b100100);
    localparam logic [OPBIT-1:0] OP_OR  = OPBIT'(6'b100101);
    localparam logic [OPBIT-1:0] OP_XOR = OPBIT'(6'b100110);
    localparam logic [OPBIT-1:0] OP_NOR = OPBIT'(6'b100111);
    localparam logic [OPBIT-1:0] OP_SRA = OPBIT'(6'b000011);
    localparam logic [OPBIT-1:0] OP_SRL = OPBIT'(6'b000010);

    state_t            state;
    logic [DBIT-1:0]   a;
    logic [DBIT-1:0]   b;
    logic [DBIT-1:0]   result;
    logic [OPBIT-1:0]  op;
    logic [DBIT-1:0]   alu_y;
    logic              alu_bad;
    logic              big_shift;

    assign op        = rx_data[OPBIT-1:0];
    assign big_shift = 32'(b) >= DBIT;

    always_comb begin
        alu_y   = '0;
        alu_bad = 1'b0;
        case (op)
            OP_ADD: alu_y = a + b;
            OP_SUB: alu_y = a - b;
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_NOR: alu_y = ~(a | b);
            OP_SRA: alu_y = big_shift ? {DBIT{a[DBIT-1]}}
                                      : DBIT'($signed(a) >>> b);
            OP_SRL: alu_y = big_shift ? '0 : (a >> b);
            default: alu_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE_A;
            a        <= '0;
            b        <= '0;
            result   <= '0;
            tx_start <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                IDLE_A: if (rx_done_tick) begin
                    a     <= rx_data;
                    state <= WAIT_B;
                end
                WAIT_B: if (rx_done_tick) begin
                    b     <= rx_data;
                    state <= WAIT_OP;
                end
                WAIT_OP: if (rx_done_tick) begin
                    result   <= alu_y;
                    op_err   <= alu_bad;
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: state <= WAIT_TX;
                WAIT_TX: if (tx_done_tick) state <= IDLE_A;
                default: state <= IDLE_A;
            endcase
        end
    end

    // Bytes arriving while a result is in flight are dropped, flagged at once.
    assign ovr_tick = rx_done_tick && (state == SEND || state == WAIT_TX);
    assign busy     = (state != IDLE_A);
    assign tx_data  = result;

endmodule
